npc_dmem_ctrl: RTL

- Parametrised unified memory for the NPC core; replaces the fixed 128-word, single-cycle, combinational-read memory.
- Two independent ports:
  - instruction fetch (IF): 32-bit reads only;
  - data (D): byte/half/word/double loads and stores.
- Both ports use a valid/ready request and a pulsed response.
- Read latency is programmable so the pipeline can be exercised against slow memory.

---
 rtl/npc_dmem_ctrl_pkg.sv | 60 ++++++
 rtl/npc_dmem_ctrl_port_fsm.sv | 89 ++++++++
 rtl/npc_dmem_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/npc_dmem_ctrl_pkg.sv
// Shared definitions for the NPC unified memory: access sizes, port FSM
// states, default base address and the byte-lane helper functions.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  localparam logic [31:0] NPC_BASE_ADDR = 32'h8000_0000;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size_e'(size))
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      SZ_D:    m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // Byte enables for a store of the given size starting at byte offset off.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size_e'(size))
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      SZ_D:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Extend a right-aligned load lane to the full 64-bit result.
  function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [1:0] size,
                                           input logic uns);
    logic [63:0] r;
    case (size_e'(size))
      SZ_B:    r = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      SZ_H:    r = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SZ_W:    r = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      SZ_D:    r = raw;
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/npc_dmem_ctrl_port_fsm.sv
// Request/response sequencer for one memory port: valid/ready accept,
// programmable read latency and a held response register.
module mem_port_fsm
  import npc_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned RSP_W  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [RSP_W-1:0] rsp_data_i,
  input  logic             rsp_err_i,
  output logic             rsp_valid_o,
  output logic [RSP_W-1:0] rsp_data_o,
  output logic             rsp_err_o
);

  // BUSY counts down from RD_LAT-2 so that accept-to-RESP spans RD_LAT cycles.
  localparam logic [1:0] CNT_INIT = (RD_LAT > 32'd1) ? 2'(RD_LAT - 32'd2) : 2'd0;

  port_state_e      state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [RSP_W-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             ready_q, rsp_valid_q;
  logic             accept_s;

  assign accept_s    = req_valid_i & ready_q;
  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

  // Next-state, latency counter and response capture at accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          data_d = rsp_data_i;
          err_d  = rsp_err_i;
          if (RD_LAT == 32'd1) begin
            state_d = ST_RESP;
            cnt_d   = 2'd0;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, response register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      data_q      <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      err_q       <= err_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
    end
  end

endmodule

// File: rtl/npc_dmem_ctrl.sv
// Unified NPC memory with an instruction-fetch port and a data port.
// Reads are sampled at accept, so a same-cycle store is not seen by a
// concurrent fetch; storage itself is never reset.
module npc_dmem_ctrl
  import npc_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = NPC_BASE_ADDR,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [31:0]       if_addr_i,
  output logic              if_rsp_valid_o,
  output logic [31:0]       if_rsp_instr_o,
  output logic              if_rsp_err_o,
  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic              d_req_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [1:0]        d_size_i,
  input  logic              d_unsigned_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_rsp_valid_o,
  output logic [DATA_W-1:0] d_rsp_rdata_o,
  output logic              d_rsp_err_o
);

  localparam int unsigned OFF_W   = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]    if_idx_s, d_idx_s;
  logic                if_err_s, d_err_s;
  logic [DATA_W-1:0]   if_word_s, if_lane_s;
  logic [31:0]         if_instr_s;
  logic [OFF_W-1:0]    d_boff_s;
  logic [DATA_W-1:0]   d_word_s, d_raw_s, d_rdata_s, d_wsh_s;
  logic [DATA_W/8-1:0] d_bmask_s;
  logic                d_accept_s, d_wr_en_s;

  function automatic logic out_of_range(input logic [31:0] addr);
    return (addr < BASE_ADDR) || (((addr - BASE_ADDR) >> OFF_W) >= DEPTH_L);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> OFF_W);
  endfunction

  // Fetch decode: 32-bit lane of the addressed word, zeroed on error.
  always_comb begin
    if_idx_s  = word_index(if_addr_i);
    if_err_s  = out_of_range(if_addr_i) | (if_addr_i[1:0] != 2'b00);
    if_word_s = mem_q[if_idx_s];
    if_lane_s = if_word_s >> {if_addr_i[OFF_W-1:2], 5'd0};
    if (if_err_s) begin
      if_instr_s = 32'd0;
    end else begin
      if_instr_s = if_lane_s[31:0];
    end
  end

  // Data decode: alignment/range check, load extraction and store lanes.
  always_comb begin
    d_idx_s   = word_index(d_addr_i);
    d_boff_s  = d_addr_i[OFF_W-1:0];
    d_err_s   = out_of_range(d_addr_i) | ((d_addr_i[2:0] & align_mask(d_size_i)) != 3'b000);
    d_word_s  = mem_q[d_idx_s];
    d_raw_s   = d_word_s >> {d_boff_s, 3'd0};
    d_bmask_s = byte_mask(d_size_i, d_boff_s);
    d_wsh_s   = d_wdata_i << {d_boff_s, 3'd0};
    if (d_err_s || d_req_we_i) begin
      d_rdata_s = '0;
    end else begin
      d_rdata_s = load_ext(d_raw_s, d_size_i, d_unsigned_i);
    end
  end

  assign d_accept_s = d_req_valid_i & d_req_ready_o;
  assign d_wr_en_s  = d_accept_s & d_req_we_i & ~d_err_s;

  // Storage write in the accept cycle; untouched by reset.
  always_ff @(posedge clk) begin
    if (d_wr_en_s) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (d_bmask_s[b]) begin
          mem_q[d_idx_s][8*b +: 8] <= d_wsh_s[8*b +: 8];
        end
      end
    end
  end

  mem_port_fsm #(.RD_LAT(RD_LAT), .RSP_W(32)) u_if_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (if_req_valid_i),
    .req_ready_o (if_req_ready_o),
    .rsp_data_i  (if_instr_s),
    .rsp_err_i   (if_err_s),
    .rsp_valid_o (if_rsp_valid_o),
    .rsp_data_o  (if_rsp_instr_o),
    .rsp_err_o   (if_rsp_err_o)
  );

  mem_port_fsm #(.RD_LAT(RD_LAT), .RSP_W(DATA_W)) u_d_port (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (d_req_valid_i),
    .req_ready_o (d_req_ready_o),
    .rsp_data_i  (d_rdata_s),
    .rsp_err_i   (d_err_s),
    .rsp_valid_o (d_rsp_valid_o),
    .rsp_data_o  (d_rsp_rdata_o),
    .rsp_err_o   (d_rsp_err_o)
  );

endmodule
